// File: rtl/x_uart_pkg.sv
// Shared UART types and constants for the receive path (and the future transmit path).
package x_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

endpackage

// File: rtl/x_sync.sv
// Purpose: STAGES-deep single-bit synchroniser with a parameterised reset value.
// Latency: STAGES i_clk cycles from i_d to o_q.
// Backpressure: none; samples every cycle.
module x_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  if (STAGES < 2) begin : g_stages_chk
    $error("x_sync: STAGES must be >= 2");
  end

  logic [STAGES-1:0] q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) q <= {STAGES{RST_VAL}};
    else       q <= {q[STAGES-2:0], i_d};
  end

  assign o_q = q[STAGES-1];

endmodule

// File: rtl/x_uart_rx.sv
// Purpose: 8N1 LSB-first UART receiver producing one-cycle byte / framing-error strobes.
// Latency: o_valid SYNC_STAGES + 9.5*CLKS_PER_BIT + 1 cycles after the falling start edge.
// Backpressure: none; every strobe must be consumed by the downstream stage.
module x_uart_rx
  import x_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rx,
  output logic                      o_valid,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic                      o_frame_err
);

  if (CLKS_PER_BIT < 4) begin : g_cpb_chk
    $error("x_uart_rx: CLKS_PER_BIT must be >= 4");
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("x_uart_rx: SYNC_STAGES must be >= 2");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  logic rx_s;

  x_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_rx),
    .o_q  (rx_s)
  );

  uart_rx_state_t            state, state_nxt;
  logic [CW-1:0]             cnt, cnt_nxt;
  logic [IW-1:0]             idx, idx_nxt;
  logic [UART_DATA_BITS-1:0] shift, shift_nxt;
  logic [UART_DATA_BITS-1:0] data_nxt;
  logic                      valid_nxt, ferr_nxt;
  logic                      cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      shift       <= shift_nxt;
      o_data      <= data_nxt;
      o_valid     <= valid_nxt;
      o_frame_err <= ferr_nxt;
    end
  end

  // Counter reloads place every sample at the middle of a bit cell.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    data_nxt  = o_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = CNT_HALF;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - 1'b1;
        end else if (rx_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DATA;
          idx_nxt   = '0;
          cnt_nxt   = CNT_BIT;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          shift_nxt = {rx_s, shift[UART_DATA_BITS-1:1]};
          cnt_nxt   = CNT_BIT;
          if (idx == IDX_LAST) state_nxt = STOP;
          else                 idx_nxt   = idx + 1'b1;
        end
      end
      STOP: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - 1'b1;
        end else if (rx_s) begin
          state_nxt = IDLE;
          valid_nxt = 1'b1;
          data_nxt  = shift;
        end else begin
          state_nxt = BREAK;
          ferr_nxt  = 1'b1;
        end
      end
      BREAK: begin
        // A held-low line stays here so it reports only one framing error.
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_x_uart_rx.sv
// Self-checking bench for x_uart_rx: serial frames are generated in time units,
// received strobes are logged by a monitor and compared to expectations derived from the frames sent.
module tb_x_uart_rx;

  localparam int CPB  = 8;
  localparam int SYNC = 2;
  localparam int TCLK = 100;
  localparam int TBIT = CPB * TCLK;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  x_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_frame_err(o_frame_err)
  );

  always #(TCLK/2) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: logs strobes and counts protocol violations (overlap, consecutive strobes, unstable data).
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         ferr_cnt = 0;
  int         viol     = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] held = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_strobe = 1'b0;
      held        = 8'h00;
    end else begin
      if (o_valid && o_frame_err) viol++;
      if ((o_valid || o_frame_err) && prev_strobe) viol++;
      if (o_valid) begin
        rx_q.push_back(o_data);
        rx_t.push_back(cyc);
        held = o_data;
      end else if (o_data !== held) begin
        viol++;
      end
      if (o_frame_err) ferr_cnt++;
      prev_strobe = o_valid || o_frame_err;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_t);
    rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_t);
    end
    rx = stop;
    #(bit_t);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", o_data); end
    n_checks++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", o_frame_err); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    #1;
    n_checks++; if (o_valid !== 1'b0 || o_frame_err !== 1'b0) begin n_fail++; $display("FAIL idle_strobes: got %b%b expected 00", o_valid, o_frame_err); end
    n_checks++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL idle_data: got %h expected 00", o_data); end
  endtask

  task automatic test_single_byte();
    int q0, f0, t0, lat;
    logic [7:0] got;
    q0 = rx_q.size(); f0 = ferr_cnt;
    @(posedge clk); #1;
    t0 = cyc;
    send_frame(8'hA5, 1'b1, TBIT);
    #(2 * TBIT);
    got = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
    lat = (rx_t.size() > q0) ? rx_t[q0] - t0 : -1;
    n_checks++; if (rx_q.size() - q0 !== 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", rx_q.size() - q0); end
    n_checks++; if (got !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", got); end
    n_checks++; if (lat < 78 || lat > 80) begin n_fail++; $display("FAIL single_latency: got %0d expected 79 +/-1", lat); end
    n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d expected 0", ferr_cnt - f0); end
    repeat (1000) @(posedge clk);
    #1;
    n_checks++; if (o_data !== 8'hA5) begin n_fail++; $display("FAIL single_hold: got %h expected a5", o_data); end
    n_checks++; if (rx_q.size() - q0 !== 1) begin n_fail++; $display("FAIL single_no_extra: got %0d expected 1", rx_q.size() - q0); end
  endtask

  task automatic test_back_to_back();
    int q0, gap;
    logic [7:0] g0, g1;
    q0 = rx_q.size();
    @(posedge clk); #1;
    send_frame(8'h00, 1'b1, TBIT);
    send_frame(8'hFF, 1'b1, TBIT);
    #(2 * TBIT);
    g0  = (rx_q.size() > q0)     ? rx_q[q0]     : 8'hxx;
    g1  = (rx_q.size() > q0 + 1) ? rx_q[q0 + 1] : 8'hxx;
    gap = (rx_t.size() > q0 + 1) ? rx_t[q0 + 1] - rx_t[q0] : -1;
    n_checks++; if (rx_q.size() - q0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", rx_q.size() - q0); end
    n_checks++; if (g0 !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h expected 00", g0); end
    n_checks++; if (g1 !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h expected ff", g1); end
    n_checks++; if (gap < 79 || gap > 81) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 80 +/-1", gap); end
  endtask

  task automatic test_glitch();
    int q0, f0;
    logic [7:0] got;
    q0 = rx_q.size(); f0 = ferr_cnt;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    #(3 * TBIT);
    n_checks++; if (rx_q.size() - q0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", rx_q.size() - q0); end
    n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt - f0); end
    send_frame(8'h3C, 1'b1, TBIT);
    #(2 * TBIT);
    got = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
    n_checks++; if (got !== 8'h3C) begin n_fail++; $display("FAIL glitch_recover: got %h expected 3c", got); end
  endtask

  task automatic test_break(input logic [7:0] prior);
    int q0, f0;
    logic [7:0] got;
    q0 = rx_q.size(); f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, TBIT);
    rx = 1'b0;
    #(20 * TBIT);
    n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL break_ferr_count: got %0d expected 1", ferr_cnt - f0); end
    n_checks++; if (rx_q.size() - q0 !== 0) begin n_fail++; $display("FAIL break_valid: got %0d expected 0", rx_q.size() - q0); end
    n_checks++; if (o_data !== prior) begin n_fail++; $display("FAIL break_data_kept: got %h expected %h", o_data, prior); end
    rx = 1'b1;
    #(2 * TBIT);
    send_frame(8'h81, 1'b1, TBIT);
    #(2 * TBIT);
    got = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
    n_checks++; if (got !== 8'h81) begin n_fail++; $display("FAIL break_recover: got %h expected 81", got); end
    n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL break_ferr_final: got %0d expected 1", ferr_cnt - f0); end
  endtask

  task automatic test_reset_mid_byte();
    int q0, f0;
    logic [7:0] b, got;
    b = 8'hF0;
    rx = 1'b0;
    #(TBIT);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(TBIT);
    end
    rx = b[4];
    #(TBIT / 2);
    rst = 1'b1;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", o_data); end
    n_checks++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_ferr: got %b expected 0", o_frame_err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Rest of 0xF0 (bits 5..7, stop) is all ones, then two idle bit times.
    #(6 * TBIT);
    q0 = rx_q.size(); f0 = ferr_cnt;
    send_frame(8'h12, 1'b1, TBIT);
    #(2 * TBIT);
    got = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
    n_checks++; if (rx_q.size() - q0 !== 1) begin n_fail++; $display("FAIL midrst_count: got %0d expected 1", rx_q.size() - q0); end
    n_checks++; if (got !== 8'h12) begin n_fail++; $display("FAIL midrst_recover: got %h expected 12", got); end
  endtask

  task automatic test_cmd_chain();
    logic [7:0] seq [5] = '{8'hD0, 8'hE0, 8'hA0, 8'hD0, 8'h01};
    int q0;
    logic [15:0] acc;
    logic [7:0]  b, pres;
    q0   = rx_q.size();
    acc  = 16'h0000;
    pres = 8'hxx;
    for (int i = 0; i < 5; i++) send_frame(seq[i], 1'b1, TBIT);
    #(2 * TBIT);
    n_checks++; if (rx_q.size() - q0 !== 5) begin n_fail++; $display("FAIL chain_count: got %0d expected 5", rx_q.size() - q0); end
    // Command-driver model: nibble 0 loads payload nibble, nibble 1 unloads the oldest byte.
    for (int i = 0; i < 5; i++) begin
      b = (rx_q.size() > q0 + i) ? rx_q[q0 + i] : 8'hxx;
      n_checks++; if (b !== seq[i]) begin n_fail++; $display("FAIL chain_byte%0d: got %h expected %h", i, b, seq[i]); end
      if (b[3:0] == 4'h0)      acc  = {acc[11:0], b[7:4]};
      else if (b[3:0] == 4'h1) pres = acc[15:8];
    end
    n_checks++; if (pres !== 8'hDE) begin n_fail++; $display("FAIL chain_present: got %h expected de", pres); end
  endtask

  task automatic test_baud_skew();
    int per [2] = '{TBIT * 103 / 100, TBIT * 97 / 100};
    int q0, f0;
    logic [7:0] got;
    for (int k = 0; k < 2; k++) begin
      q0 = rx_q.size(); f0 = ferr_cnt;
      #(2 * TBIT);
      send_frame(8'hA5, 1'b1, per[k]);
      #(3 * TBIT);
      got = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
      n_checks++; if (rx_q.size() - q0 !== 1) begin n_fail++; $display("FAIL skew%0d_count: got %0d expected 1", per[k], rx_q.size() - q0); end
      n_checks++; if (got !== 8'hA5) begin n_fail++; $display("FAIL skew%0d_data: got %h expected a5", per[k], got); end
      n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL skew%0d_ferr: got %0d expected 0", per[k], ferr_cnt - f0); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int exp_ferr, q0, f0, bt, gap;
    logic [7:0] b, got;
    logic bad;
    exp_ferr = 0;
    q0 = rx_q.size(); f0 = ferr_cnt;
    for (int n = 0; n < 16; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      bt  = TBIT - 16 + 16 * int'($urandom_range(0, 2));
      send_frame(b, !bad, bt);
      if (bad) begin
        exp_ferr++;
        gap = int'($urandom_range(1, 3));
      end else begin
        exp_q.push_back(b);
        gap = int'($urandom_range(0, 3));
      end
      #(gap * TBIT);
    end
    #(3 * TBIT);
    n_checks++; if (rx_q.size() - q0 !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", rx_q.size() - q0, exp_q.size()); end
    n_checks++; if (ferr_cnt - f0 !== exp_ferr) begin n_fail++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt - f0, exp_ferr); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (rx_q.size() > q0 + i) ? rx_q[q0 + i] : 8'hxx;
      n_checks++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %h expected %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_protocol();
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL protocol_violations: got %0d expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    #(2 * TBIT);
    test_back_to_back();
    #(2 * TBIT);
    test_glitch();
    #(2 * TBIT);
    test_break(8'h3C);
    #(2 * TBIT);
    test_reset_mid_byte();
    #(2 * TBIT);
    test_cmd_chain();
    #(2 * TBIT);
    test_baud_skew();
    #(2 * TBIT);
    test_random();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
